// File: rtl/pwrmgr_rst_arb_if.sv
// ---------------------------------------------------------------------------
// pwrmgr_rst_arb_if
// Bundles the reset-request arbiter's request sources, fast-FSM handshake and
// software-visible outputs.
//   rstreq_i     [NumSrc]   peripheral reset requests (level)
//   rstreq_en_i  [NumSrc]   per-source enables
//   esc_rst_i               escalation reset request (level)
//   fsm_active_i            fast FSM in active state
//   rst_ack_i               reset path entered
//   rst_done_i              reset path complete (pulse)
//   cause_clr_i             clear sticky cause (pulse)
//   reset_reqs_o [NumSrc+1] request vector to the fast FSM
//   cause_o      [NumSrc+1] sticky granted-cause record
//   busy_o                  arbiter not idle
// Modports: slave = arbiter side, master = requester / fast-FSM side.
// ---------------------------------------------------------------------------
interface pwrmgr_rst_arb_if #(
    parameter int unsigned NumSrc = 4
) ();
    logic [NumSrc-1:0] rstreq_i;
    logic [NumSrc-1:0] rstreq_en_i;
    logic              esc_rst_i;
    logic              fsm_active_i;
    logic              rst_ack_i;
    logic              rst_done_i;
    logic              cause_clr_i;
    logic [NumSrc:0]   reset_reqs_o;
    logic [NumSrc:0]   cause_o;
    logic              busy_o;

    modport slave (
        input  rstreq_i, rstreq_en_i, esc_rst_i, fsm_active_i,
        input  rst_ack_i, rst_done_i, cause_clr_i,
        output reset_reqs_o, cause_o, busy_o
    );

    modport master (
        output rstreq_i, rstreq_en_i, esc_rst_i, fsm_active_i,
        output rst_ack_i, rst_done_i, cause_clr_i,
        input  reset_reqs_o, cause_o, busy_o
    );
endinterface

// File: rtl/pwrmgr_rst_arb.sv
// ---------------------------------------------------------------------------
// pwrmgr_rst_arb
// Reset-request arbiter in front of the power manager fast FSM. Qualifies
// enabled peripheral requests, picks the lowest-index one (escalation, index
// NumSrc, always wins), and holds a registered one-hot request towards the fast
// FSM until the reset path completes. Granted causes are recorded in a sticky
// register for readback after reboot.
// Ports:
//   clk_i   fast power-manager clock
//   rst_ni  asynchronous active-low reset
//   bus     pwrmgr_rst_arb_if.slave (requests, handshake, outputs)
// Build option:
//   PWRMGR_RST_FILTER_EN  when defined, a peripheral request must persist
//                         through a Filter state for FilterCycles cycles before
//                         it is granted. When undefined, a qualified request
//                         goes straight to Req and FilterCycles is unused.
// ---------------------------------------------------------------------------
module pwrmgr_rst_arb #(
    parameter int unsigned NumSrc       = 4,
    parameter int unsigned FilterCycles = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    pwrmgr_rst_arb_if.slave bus
);
    localparam int unsigned NumReq = NumSrc + 1;
    localparam int unsigned GntW   = $clog2(NumReq);
    localparam logic [GntW-1:0] EscIdx = GntW'(NumSrc);

    if ((NumSrc < 1) || (NumSrc > 16) || (FilterCycles < 2) || (FilterCycles > 255))
    begin : gen_param_check
        $error("pwrmgr_rst_arb: NumSrc or FilterCycles out of range");
    end

    typedef enum logic [1:0] {StIdle, StFilter, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic [GntW-1:0]   grant_q, grant_d;
    logic [NumReq-1:0] reset_reqs_q, reset_reqs_d;
    logic [NumReq-1:0] cause_q, cause_d;
    logic [NumReq-1:0] cause_set;
    logic [NumReq-1:0] grant_oh_d;

    logic [NumSrc-1:0] qual;
    logic              any_qual;
    logic [GntW-1:0]   pick;

`ifdef PWRMGR_RST_FILTER_EN
    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] grant_oh_q;
    logic              src_hold;

    // The filtered source must stay both requested and enabled; fsm_active is
    // only a qualifier for acceptance in Idle.
    assign grant_oh_q = NumReq'(1) << grant_q;
    assign src_hold   = |(grant_oh_q[NumSrc-1:0] & bus.rstreq_i & bus.rstreq_en_i);
`endif

    assign qual     = bus.rstreq_i & bus.rstreq_en_i & {NumSrc{bus.fsm_active_i}};
    assign any_qual = |qual;

    // Fixed priority: lowest set index wins.
    always_comb begin
        pick = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (qual[i]) begin
                pick = GntW'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            reset_reqs_q <= '0;
            cause_q      <= '0;
`ifdef PWRMGR_RST_FILTER_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            reset_reqs_q <= reset_reqs_d;
            cause_q      <= cause_d;
`ifdef PWRMGR_RST_FILTER_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifdef PWRMGR_RST_FILTER_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.esc_rst_i) begin
                    state_d = StReq;
                    grant_d = EscIdx;
                end else if (any_qual) begin
                    grant_d = pick;
`ifdef PWRMGR_RST_FILTER_EN
                    cnt_d   = '0;
                    state_d = StFilter;
`else
                    state_d = StReq;
`endif
                end
            end
`ifdef PWRMGR_RST_FILTER_EN
            StFilter: begin
                if (bus.esc_rst_i) begin
                    state_d = StReq;
                    grant_d = EscIdx;
                end else if (!src_hold) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StReq: begin
                if (bus.rst_ack_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.rst_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign grant_oh_d = NumReq'(1) << grant_d;

    // Registered-output next values.
    always_comb begin
        reset_reqs_d = reset_reqs_q;
        cause_set    = '0;
        // Entering Req from Idle/Filter loads the one-hot grant.
        if ((state_q != StReq) && (state_q != StWait) && (state_d == StReq)) begin
            reset_reqs_d = grant_oh_d;
            cause_set    = grant_oh_d;
        end
        // Escalation during a peripheral reset request is overlaid, not swapped.
        if ((state_q == StReq) && bus.esc_rst_i && (grant_q != EscIdx)) begin
            reset_reqs_d[NumSrc] = 1'b1;
            cause_set[NumSrc]    = 1'b1;
        end
        if ((state_q == StWait) && bus.rst_done_i) begin
            reset_reqs_d = '0;
        end
        // A same-cycle set survives a clear.
        cause_d = (bus.cause_clr_i ? '0 : cause_q) | cause_set;
    end

    assign bus.reset_reqs_o = reset_reqs_q;
    assign bus.cause_o      = cause_q;
    assign bus.busy_o       = (state_q != StIdle);
endmodule

// File: tb/tb_pwrmgr_rst_arb.sv
module tb_pwrmgr_rst_arb;
    localparam int unsigned NumSrc       = 4;
    localparam int unsigned FilterCycles = 4;
`ifdef PWRMGR_RST_FILTER_EN
    localparam int unsigned RiseEdge = FilterCycles;
`else
    localparam int unsigned RiseEdge = 0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;

    pwrmgr_rst_arb_if #(.NumSrc(NumSrc)) bus ();

    pwrmgr_rst_arb #(
        .NumSrc      (NumSrc),
        .FilterCycles(FilterCycles)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] reqs, input logic [4:0] cause,
                           input logic busy);
        chk({tag, ".reqs"}, 32'(bus.reset_reqs_o), 32'(reqs));
        chk({tag, ".cause"}, 32'(bus.cause_o), 32'(cause));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(busy));
    endtask

    task automatic release_path();
        bus.rstreq_i   = '0;
        bus.esc_rst_i  = 1'b0;
        bus.rst_ack_i  = 1'b1;
        step();
        bus.rst_ack_i  = 1'b0;
        bus.rst_done_i = 1'b1;
        step();
        bus.rst_done_i = 1'b0;
    endtask

    task automatic clr_cause();
        bus.cause_clr_i = 1'b1;
        step();
        bus.cause_clr_i = 1'b0;
    endtask

    // Hold the current request and step up to the grant edge.
    task automatic run_grant(input string tag, input logic [4:0] exp);
        for (int e = 0; e <= int'(RiseEdge); e++) begin
            step();
            chk_out(tag, (e == int'(RiseEdge)) ? exp : 5'b0,
                    (e == int'(RiseEdge)) ? exp : 5'b0, 1'b1);
        end
    endtask

    initial begin
        bus.rstreq_i     = '0;
        bus.rstreq_en_i  = '0;
        bus.esc_rst_i    = 1'b0;
        bus.fsm_active_i = 1'b0;
        bus.rst_ack_i    = 1'b0;
        bus.rst_done_i   = 1'b0;
        bus.cause_clr_i  = 1'b0;
        step();
        step();
        chk_out("reset", 5'b0, 5'b0, 1'b0);
        rst_ni = 1'b1;
        step();

        // Single peripheral source 2.
        bus.rstreq_en_i  = 4'b1111;
        bus.fsm_active_i = 1'b1;
        bus.rstreq_i     = 4'b0100;
        run_grant("src2", 5'b00100);
        release_path();
        chk_out("src2_rel", 5'b0, 5'b00100, 1'b0);
        clr_cause();
        chk("src2_clr", 32'(bus.cause_o), 32'h0);

`ifdef PWRMGR_RST_FILTER_EN
        // Request drops before the filter completes.
        bus.rstreq_i = 4'b0100;
        step();
        step();
        step();
        chk_out("glitch_flt", 5'b0, 5'b0, 1'b1);
        bus.rstreq_i = 4'b0000;
        step();
        chk_out("glitch_idle", 5'b0, 5'b0, 1'b0);
        step();
        chk_out("glitch_stay", 5'b0, 5'b0, 1'b0);
`endif

        // Simultaneous requests: lowest index wins.
        bus.rstreq_i = 4'b1010;
        run_grant("prio1", 5'b00010);
        release_path();
        chk_out("prio1_rel", 5'b0, 5'b00010, 1'b0);
        clr_cause();

        // Source 1 disabled: source 3 wins.
        bus.rstreq_en_i = 4'b1101;
        bus.rstreq_i    = 4'b1010;
        run_grant("prio3", 5'b01000);
        release_path();
        clr_cause();
        bus.rstreq_en_i = 4'b1111;
        chk_out("prio3_done", 5'b0, 5'b0, 1'b0);

        // Escalation preempts a pending peripheral request.
        bus.rstreq_i = 4'b0010;
`ifdef PWRMGR_RST_FILTER_EN
        step();
        step();
        step();
        chk_out("esc_flt", 5'b0, 5'b0, 1'b1);
`endif
        bus.esc_rst_i = 1'b1;
        step();
        bus.esc_rst_i = 1'b0;
        chk_out("esc_pre", 5'b10000, 5'b10000, 1'b1);
        step();
        chk_out("esc_hold", 5'b10000, 5'b10000, 1'b1);
        release_path();
        clr_cause();

        // Source 0: hold through Wait, release, sticky cause.
        bus.rstreq_i = 4'b0001;
        run_grant("src0", 5'b00001);
        bus.rstreq_i = 4'b0000;
        step();
        chk("src0_hold", 32'(bus.reset_reqs_o), 32'h01);
        bus.rst_ack_i = 1'b1;
        step();
        bus.rst_ack_i = 1'b0;
        chk_out("src0_wait", 5'b00001, 5'b00001, 1'b1);
        bus.esc_rst_i = 1'b1;
        bus.rstreq_i  = 4'b1111;
        step();
        step();
        step();
        bus.esc_rst_i = 1'b0;
        bus.rstreq_i  = 4'b0000;
        chk_out("wait_ignore", 5'b00001, 5'b00001, 1'b1);
        bus.rst_done_i = 1'b1;
        step();
        bus.rst_done_i = 1'b0;
        chk_out("src0_done", 5'b0, 5'b00001, 1'b0);
        step();
        chk("sticky", 32'(bus.cause_o), 32'h01);

        // Clear coincident with a new grant keeps only the new bit.
        bus.rstreq_i = 4'b1000;
        repeat (RiseEdge) step();
        bus.cause_clr_i = 1'b1;
        step();
        bus.cause_clr_i = 1'b0;
        chk_out("clr_set", 5'b01000, 5'b01000, 1'b1);

        // Escalation overlay on an active peripheral request.
        bus.esc_rst_i = 1'b1;
        step();
        bus.esc_rst_i = 1'b0;
        chk_out("overlay", 5'b11000, 5'b11000, 1'b1);
        release_path();
        chk_out("overlay_rel", 5'b0, 5'b11000, 1'b0);
        clr_cause();

        // fsm_active low: peripheral ignored, escalation still accepted.
        bus.fsm_active_i = 1'b0;
        bus.rstreq_i     = 4'b0001;
        step();
        step();
        step();
        chk_out("inactive", 5'b0, 5'b0, 1'b0);
        bus.esc_rst_i = 1'b1;
        step();
        bus.esc_rst_i = 1'b0;
        chk_out("inactive_esc", 5'b10000, 5'b10000, 1'b1);
        release_path();
        clr_cause();
        bus.fsm_active_i = 1'b1;

        // Asynchronous reset while a request is held.
        bus.rstreq_i = 4'b0100;
        run_grant("pre_arst", 5'b00100);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_out("arst", 5'b0, 5'b0, 1'b0);
        bus.rstreq_i = 4'b0000;
        step();
        rst_ni = 1'b1;
        step();
        chk_out("post_arst", 5'b0, 5'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
